// File: rtl/calc_dispatcher.sv
// rtl/calc_dispatcher.sv - request sequencer between menu FSM and matrix calculator core
// Optional watchdog in WAIT: define CALC_TIMEOUT_EN
module calc_dispatcher #(
  parameter int unsigned MAX_DIM        = 5,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [2:0]  i_op_code,
  input  logic [7:0]  i_op1_addr,
  input  logic [7:0]  i_op2_addr,
  input  logic [7:0]  i_res_addr,
  input  logic [31:0] i_op1_m,
  input  logic [31:0] i_op1_n,
  input  logic [31:0] i_op2_m,
  input  logic [31:0] i_op2_n,
  output logic        o_busy,
  output logic        o_start_calc,
  output logic [2:0]  o_op_code,
  output logic [7:0]  o_op1_addr,
  output logic [7:0]  o_op2_addr,
  output logic [7:0]  o_res_addr,
  output logic [31:0] o_op1_m,
  output logic [31:0] o_op1_n,
  output logic [31:0] o_op2_m,
  output logic [31:0] o_op2_n,
  input  logic        i_calc_done,
  output logic        o_core_sel,
  output logic        o_done,
  output logic        o_err,
  output logic [2:0]  o_err_code,
  output logic [31:0] o_res_m,
  output logic [31:0] o_res_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_START,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [2:0] OP_TRANSPOSE = 3'b000;
  localparam logic [2:0] OP_ADD       = 3'b001;
  localparam logic [2:0] OP_MULTIPLY  = 3'b010;
  localparam logic [2:0] OP_SCALAR    = 3'b011;

  localparam logic [2:0] ERR_NONE     = 3'b000;
  localparam logic [2:0] ERR_OP       = 3'b001;
  localparam logic [2:0] ERR_RANGE    = 3'b010;
  localparam logic [2:0] ERR_MISMATCH = 3'b011;
  localparam logic [2:0] ERR_TIMEOUT  = 3'b100;

  state_t      state;
  state_t      state_next;
  logic [2:0]  err_code;
  logic [2:0]  chk_code;
  logic [31:0] chk_m;
  logic [31:0] chk_n;
  logic        use_op2;
  logic        wd_expire;

  // Full-width range test, so oversized dimensions never alias into range
  function automatic logic dim_ok(input logic [31:0] d);
    return (d >= 32'd1) && (d <= 32'(MAX_DIM));
  endfunction

  // Validate the latched request in priority order and derive result dims
  always_comb begin
    chk_code = ERR_NONE;
    chk_m    = '0;
    chk_n    = '0;
    use_op2  = (o_op_code != OP_TRANSPOSE);
    if (o_op_code > OP_SCALAR) begin
      chk_code = ERR_OP;
    end else if (!dim_ok(o_op1_m) || !dim_ok(o_op1_n) ||
                 (use_op2 && (!dim_ok(o_op2_m) || !dim_ok(o_op2_n)))) begin
      chk_code = ERR_RANGE;
    end else begin
      case (o_op_code)
        OP_TRANSPOSE: begin
          chk_m = o_op1_n;
          chk_n = o_op1_m;
        end
        OP_ADD: begin
          if ((o_op1_m != o_op2_m) || (o_op1_n != o_op2_n)) begin
            chk_code = ERR_MISMATCH;
          end else begin
            chk_m = o_op1_m;
            chk_n = o_op1_n;
          end
        end
        OP_MULTIPLY: begin
          if (o_op1_n != o_op2_m) begin
            chk_code = ERR_MISMATCH;
          end else begin
            chk_m = o_op1_m;
            chk_n = o_op2_n;
          end
        end
        default: begin
          if ((o_op2_m != 32'd1) || (o_op2_n != 32'd1)) begin
            chk_code = ERR_MISMATCH;
          end else begin
            chk_m = o_op1_m;
            chk_n = o_op1_n;
          end
        end
      endcase
    end
  end

`ifdef CALC_TIMEOUT_EN
  logic [31:0] wd_count;

  // Count WAIT cycles; START clears it so every run starts from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_count <= '0;
    end else if (state == S_START) begin
      wd_count <= '0;
    end else if (state == S_WAIT) begin
      wd_count <= wd_count + 32'd1;
    end
  end

  assign wd_expire = (state == S_WAIT) && (wd_count == 32'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign wd_expire      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-state control outputs; completion beats the watchdog
  always_comb begin
    state_next   = state;
    o_busy       = 1'b1;
    o_start_calc = 1'b0;
    o_core_sel   = 1'b0;
    o_done       = 1'b0;
    o_err        = 1'b0;
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_req) state_next = S_CHECK;
      end
      S_CHECK: begin
        state_next = (chk_code != ERR_NONE) ? S_ERR : S_START;
      end
      S_START: begin
        o_start_calc = 1'b1;
        o_core_sel   = 1'b1;
        state_next   = S_WAIT;
      end
      S_WAIT: begin
        o_core_sel = 1'b1;
        if (i_calc_done) state_next = S_DONE;
        else if (wd_expire) state_next = S_ERR;
      end
      S_DONE: begin
        o_done     = 1'b1;
        state_next = S_IDLE;
      end
      S_ERR: begin
        o_done     = 1'b1;
        o_err      = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        o_busy     = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  // Latch request fields on acceptance; record check outcome and timeout code
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_op_code  <= '0;
      o_op1_addr <= '0;
      o_op2_addr <= '0;
      o_res_addr <= '0;
      o_op1_m    <= '0;
      o_op1_n    <= '0;
      o_op2_m    <= '0;
      o_op2_n    <= '0;
      err_code   <= ERR_NONE;
      o_res_m    <= '0;
      o_res_n    <= '0;
    end else begin
      if ((state == S_IDLE) && i_req) begin
        o_op_code  <= i_op_code;
        o_op1_addr <= i_op1_addr;
        o_op2_addr <= i_op2_addr;
        o_res_addr <= i_res_addr;
        o_op1_m    <= i_op1_m;
        o_op1_n    <= i_op1_n;
        o_op2_m    <= i_op2_m;
        o_op2_n    <= i_op2_n;
        err_code   <= ERR_NONE;
        o_res_m    <= '0;
        o_res_n    <= '0;
      end
      if (state == S_CHECK) begin
        err_code <= chk_code;
        o_res_m  <= chk_m;
        o_res_n  <= chk_n;
      end
      if ((state == S_WAIT) && !i_calc_done && wd_expire) begin
        err_code <= ERR_TIMEOUT;
        o_res_m  <= '0;
        o_res_n  <= '0;
      end
    end
  end

  assign o_err_code = err_code;

endmodule

// File: tb/tb_calc_dispatcher.sv
// tb/tb_calc_dispatcher.sv - self-checking bench for calc_dispatcher
`timescale 1ns/1ps
module tb_calc_dispatcher;
  localparam int MAX_DIM = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [2:0]  i_op_code;
  logic [7:0]  i_op1_addr, i_op2_addr, i_res_addr;
  logic [31:0] i_op1_m, i_op1_n, i_op2_m, i_op2_n;
  logic        o_busy, o_start_calc;
  logic [2:0]  o_op_code;
  logic [7:0]  o_op1_addr, o_op2_addr, o_res_addr;
  logic [31:0] o_op1_m, o_op1_n, o_op2_m, o_op2_n;
  logic        i_calc_done;
  logic        o_core_sel, o_done, o_err;
  logic [2:0]  o_err_code;
  logic [31:0] o_res_m, o_res_n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  calc_dispatcher #(.MAX_DIM(MAX_DIM)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_op_code(i_op_code),
    .i_op1_addr(i_op1_addr), .i_op2_addr(i_op2_addr), .i_res_addr(i_res_addr),
    .i_op1_m(i_op1_m), .i_op1_n(i_op1_n), .i_op2_m(i_op2_m), .i_op2_n(i_op2_n),
    .o_busy(o_busy), .o_start_calc(o_start_calc), .o_op_code(o_op_code),
    .o_op1_addr(o_op1_addr), .o_op2_addr(o_op2_addr), .o_res_addr(o_res_addr),
    .o_op1_m(o_op1_m), .o_op1_n(o_op1_n), .o_op2_m(o_op2_m), .o_op2_n(o_op2_n),
    .i_calc_done(i_calc_done), .o_core_sel(o_core_sel), .o_done(o_done),
    .o_err(o_err), .o_err_code(o_err_code), .o_res_m(o_res_m), .o_res_n(o_res_n)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a_m, a_n, b_m, b_n;
    int          delay;
    logic [2:0]  code;
    logic [31:0] rm, rn;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] d);
    return (d >= 1) && (d <= MAX_DIM);
  endfunction

  // Reference outcome straight from the operation rules
  function automatic void model(input logic [2:0] op, input logic [31:0] a_m, a_n, b_m, b_n,
                                output logic [2:0] code, output logic [31:0] rm, rn);
    bit needs_b;
    needs_b = (op == 1) || (op == 2) || (op == 3);
    code = 0; rm = 0; rn = 0;
    if (op > 3) code = 1;
    else if (!in_range(a_m) || !in_range(a_n) || (needs_b && (!in_range(b_m) || !in_range(b_n)))) code = 2;
    else if (op == 0) begin rm = a_n; rn = a_m; end
    else if (op == 1) begin
      if (a_m == b_m && a_n == b_n) begin rm = a_m; rn = a_n; end else code = 3;
    end else if (op == 2) begin
      if (a_n == b_m) begin rm = a_m; rn = b_n; end else code = 3;
    end else begin
      if (b_m == 1 && b_n == 1) begin rm = a_m; rn = a_n; end else code = 3;
    end
  endfunction

  // One request from IDLE to o_done, observed cycle by cycle at negedges
  task automatic run_txn(input logic [2:0] op, input logic [31:0] a_m, a_n, b_m, b_n,
                         input int delay, input logic [2:0] e_code, input logic [31:0] e_m, e_n);
    int cyc = 0, starts = 0, sel = 0, start_cyc = -1, done_cyc = -1;
    logic [7:0] a1, a2, ar;
    a1 = 8'($urandom); a2 = 8'($urandom); ar = 8'($urandom);
    @(negedge clk);
    i_req = 1; i_op_code = op; i_op1_addr = a1; i_op2_addr = a2; i_res_addr = ar;
    i_op1_m = a_m; i_op1_n = a_n; i_op2_m = b_m; i_op2_n = b_n;
    @(negedge clk);
    cyc = 1;
    i_req = 0; i_op_code = ~op; i_op1_addr = ~a1; i_op2_addr = ~a2; i_res_addr = ~ar;
    i_op1_m = a_m + 1; i_op1_n = a_n + 1; i_op2_m = b_m + 1; i_op2_n = b_n + 1;
    while (done_cyc < 0 && cyc < delay + 30) begin
      if (o_start_calc) begin
        starts++;
        start_cyc = cyc;
        check("lat_op", 64'(o_op_code), 64'(op));
        check("lat_addr", 64'({o_op1_addr, o_op2_addr, o_res_addr}), 64'({a1, a2, ar}));
        check("lat_op1", {o_op1_m, o_op1_n}, {a_m, a_n});
        check("lat_op2", {o_op2_m, o_op2_n}, {b_m, b_n});
      end
      if (o_core_sel) sel++;
      if (o_done) begin
        done_cyc = cyc;
        check("done_err", 64'({o_err, o_err_code}), 64'({e_code != 0, e_code}));
        check("done_res", {o_res_m, o_res_n}, {e_m, e_n});
        check("done_busy", 64'(o_busy), 64'(1));
      end
      i_calc_done = (start_cyc >= 0) && (cyc == start_cyc + delay);
      if (done_cyc < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    i_calc_done = 0;
    check("done_seen", 64'(done_cyc >= 0), 64'(1));
    check("done_cycle", 64'(done_cyc), 64'((e_code == 0) ? 3 + delay : 2));
    check("start_pulses", 64'(starts), 64'((e_code == 0) ? 1 : 0));
    check("core_sel_cycles", 64'(sel), 64'((e_code == 0) ? delay + 1 : 0));
    @(negedge clk);
    check("idle_after", 64'({o_busy, o_done, o_err_code}), 64'({1'b0, 1'b0, e_code}));
  endtask

  initial begin
    int bad;
    int start_seen;
    logic [2:0]  r_op, e_code;
    logic [31:0] r_d[4];
    logic [31:0] e_m, e_n;

    rst = 1; i_req = 0; i_op_code = 0; i_calc_done = 0;
    i_op1_addr = 0; i_op2_addr = 0; i_res_addr = 0;
    i_op1_m = 0; i_op1_n = 0; i_op2_m = 0; i_op2_n = 0;

    vecs[0]  = '{3'd2, 32'd2, 32'd3, 32'd3, 32'd4, 10, 3'd0, 32'd2, 32'd4};
    vecs[1]  = '{3'd1, 32'd2, 32'd3, 32'd3, 32'd2, 1,  3'd3, 32'd0, 32'd0};
    vecs[2]  = '{3'd7, 32'd6, 32'd6, 32'd6, 32'd6, 1,  3'd1, 32'd0, 32'd0};
    vecs[3]  = '{3'd0, 32'd6, 32'd1, 32'd0, 32'd0, 1,  3'd2, 32'd0, 32'd0};
    vecs[4]  = '{3'd0, 32'd3, 32'd5, 32'd0, 32'd0, 1,  3'd0, 32'd5, 32'd3};
    vecs[5]  = '{3'd3, 32'd4, 32'd5, 32'd1, 32'd1, 2,  3'd0, 32'd4, 32'd5};
    vecs[6]  = '{3'd3, 32'd4, 32'd5, 32'd1, 32'd2, 1,  3'd3, 32'd0, 32'd0};
    vecs[7]  = '{3'd3, 32'd4, 32'd5, 32'd0, 32'd1, 1,  3'd2, 32'd0, 32'd0};
    vecs[8]  = '{3'd2, 32'd5, 32'd5, 32'd5, 32'd1, 3,  3'd0, 32'd5, 32'd1};
    vecs[9]  = '{3'd1, 32'h102, 32'd2, 32'd2, 32'd2, 1, 3'd2, 32'd0, 32'd0};
    vecs[10] = '{3'd2, 32'd2, 32'd3, 32'd4, 32'd6, 1,  3'd2, 32'd0, 32'd0};
    vecs[11] = '{3'd4, 32'd1, 32'd1, 32'd1, 32'd1, 1,  3'd1, 32'd0, 32'd0};
    vecs[12] = '{3'd1, 32'd5, 32'd5, 32'd5, 32'd5, 1,  3'd0, 32'd5, 32'd5};
    vecs[13] = '{3'd0, 32'd1, 32'd1, 32'd7, 32'd7, 1,  3'd0, 32'd1, 32'd1};

    #12;
    check("rst_ctrl", 64'({o_busy, o_start_calc, o_core_sel, o_done, o_err, o_err_code}), 64'(0));
    check("rst_lat", 64'(|{o_op_code, o_op1_addr, o_op2_addr, o_res_addr,
                          o_op1_m, o_op1_n, o_op2_m, o_op2_n}), 64'(0));
    check("rst_res", {o_res_m, o_res_n}, 64'(0));
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 14; i++)
      run_txn(vecs[i].op, vecs[i].a_m, vecs[i].a_n, vecs[i].b_m, vecs[i].b_n,
              vecs[i].delay, vecs[i].code, vecs[i].rm, vecs[i].rn);

    for (int i = 0; i < 40; i++) begin
      r_op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++)
        r_d[k] = ($urandom_range(0, 15) == 0) ? 32'h8000_0003 : 32'($urandom_range(0, 6));
      if (r_op == 1 && $urandom_range(0, 1) == 1) begin r_d[2] = r_d[0]; r_d[3] = r_d[1]; end
      if (r_op == 2 && $urandom_range(0, 1) == 1) r_d[2] = r_d[1];
      if (r_op == 3 && $urandom_range(0, 1) == 1) begin r_d[2] = 1; r_d[3] = 1; end
      model(r_op, r_d[0], r_d[1], r_d[2], r_d[3], e_code, e_m, e_n);
      run_txn(r_op, r_d[0], r_d[1], r_d[2], r_d[3], $urandom_range(1, 5), e_code, e_m, e_n);
    end

    // i_req held high on the error path: completions every 3 cycles
    @(negedge clk);
    i_req = 1; i_op_code = 3'd7;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check($sformatf("b2b_done_c%0d", c), 64'(o_done), 64'((c % 3) == 2));
    end
    i_req = 0;
    repeat (3) @(negedge clk);

    // i_calc_done while idle does nothing
    i_calc_done = 1;
    @(negedge clk);
    i_calc_done = 0;
    check("idle_done_ignored", 64'({o_busy, o_done}), 64'(0));

    // i_calc_done during START is not sampled; no watchdog keeps WAIT alive
    i_req = 1; i_op_code = 3'd1;
    i_op1_m = 2; i_op1_n = 2; i_op2_m = 2; i_op2_n = 2;
    @(negedge clk);
    i_req = 0;
    @(negedge clk);
    start_seen = o_start_calc;
    check("start_at_c2", 64'(start_seen), 64'(1));
    i_calc_done = 1;
    @(negedge clk);
    i_calc_done = 0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (!o_busy || o_done || !o_core_sel) bad++;
      @(negedge clk);
    end
    check("wait_holds", 64'(bad), 64'(0));
    i_calc_done = 1;
    @(negedge clk);
    i_calc_done = 0;
    check("late_done", 64'({o_done, o_err, o_core_sel}), 64'({1'b1, 1'b0, 1'b0}));
    check("late_res", {o_res_m, o_res_n}, {32'd2, 32'd2});
    @(negedge clk);

    // Asynchronous reset while the core owns storage
    i_req = 1; i_op_code = 3'd2;
    i_op1_m = 2; i_op1_n = 3; i_op2_m = 3; i_op2_n = 4;
    @(negedge clk);
    i_req = 0;
    bad = 1;
    for (int c = 0; c < 10 && bad != 0; c++) begin
      if (o_core_sel && !o_start_calc) bad = 0;
      else @(negedge clk);
    end
    check("reached_wait", 64'(bad), 64'(0));
    #2 rst = 1;
    #1;
    check("async_rst", 64'({o_core_sel, o_busy, o_done}), 64'(0));
    @(negedge clk);
    rst = 0;
    i_calc_done = 1;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (o_done || o_busy) bad++;
    end
    i_calc_done = 0;
    check("no_done_after_rst", 64'(bad), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_dispatcher.md
# calc_dispatcher

Sequencer between the menu/top-level FSM and the matrix calculator core. Accepts one operation request at a time, latches operands, validates the op code and operand dimensions, pulses the core's start, grants the core the storage port while it runs, and returns a done/error status with the result dimensions. An optional watchdog aborts a core that never reports completion.

## Interface
- MAX_DIM, 5: largest legal row/column count; minimum is always 1
- TIMEOUT_CYCLES, 4096: watchdog limit in WAIT; used only with CALC_TIMEOUT_EN
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  request; sampled only in IDLE
- i_op_code  in  3  000 transpose, 001 add, 010 multiply, 011 scalar multiply; others illegal
- i_op1_addr, i_op2_addr, i_res_addr  in  8 each  storage base addresses
- i_op1_m, i_op1_n, i_op2_m, i_op2_n  in  32 each  operand dimensions
- o_busy  out  1  high in every state except IDLE
- o_start_calc  out  1  one-cycle start pulse to core
- o_op_code  out  3  latched op code to core
- o_op1_addr, o_op2_addr, o_res_addr  out  8 each  latched addresses to core
- o_op1_m, o_op1_n, o_op2_m, o_op2_n  out  32 each  latched dimensions to core
- i_calc_done  in  1  core completion
- o_core_sel  out  1  storage mux select: 1 = core owns storage read/write ports
- o_done  out  1  one-cycle completion pulse (success or error)
- o_err  out  1  valid with o_done; 1 = failed
- o_err_code  out  3  000 none, 001 illegal op, 010 dimension out of range, 011 dimension mismatch, 100 timeout
- o_res_m, o_res_n  out  32 each  result dimensions; valid from o_done until next accepted request

## Operation
- States: IDLE, CHECK, START, WAIT, DONE, ERR.
- IDLE: i_req=1 latches all op/addr/dim inputs and moves to CHECK. Inputs ignored in all other states.
- CHECK (1 cycle): evaluate in priority order. Illegal op → 001. Any operand dimension used by the op outside 1..MAX_DIM → 010. Transpose and scalar use op1 only, plus op2 for scalar. Mismatch → 011. Mismatch rules: add requires op1_m==op2_m and op1_n==op2_n. Multiply requires op1_n==op2_m. Scalar requires op2 to be 1x1. Any error → ERR, else → START.
- Result dims computed in CHECK: transpose op1_n x op1_m; add and scalar op1_m x op1_n; multiply op1_m x op2_n. Result dims are zeroed on error.
- START: o_start_calc=1, o_core_sel=1, → WAIT.
- WAIT: o_core_sel=1; i_calc_done=1 → DONE.
- DONE: o_done=1, o_err=0, o_err_code=000, o_core_sel=0; → IDLE.
- ERR: o_done=1, o_err=1, o_err_code held; → IDLE. o_err_code retains its value until the next accepted request.
- i_calc_done outside WAIT is ignored.
- Comparisons use full 32-bit widths; no truncation.

## Timing
- Reset (async, any state): state=IDLE. All outputs 0, including o_busy, o_start_calc, o_core_sel, o_done, o_err, o_err_code, latched addr/dim/op, and o_res_m/n.
- Reset mid-WAIT drops o_core_sel immediately. The core is expected to be reset by the same rst.
- Success latency: i_req sampled at edge 0. o_start_calc high in cycle 2. o_done high the cycle after i_calc_done is sampled.
- Error latency: o_done high in cycle 2, with no o_start_calc.
- i_calc_done in the same cycle as the START state is not sampled; it must arrive in WAIT.
- i_req held high: a new request is accepted on the first IDLE cycle after o_done. The minimum back-to-back spacing is 3 cycles on the error path.
- o_core_sel rises with o_start_calc and falls in the DONE/ERR cycle.

## Configuration
- CALC_TIMEOUT_EN defined: a 32-bit counter clears on entry to WAIT and increments each WAIT cycle. Reaching TIMEOUT_CYCLES without i_calc_done → ERR with code 100, releasing o_core_sel. If i_calc_done arrives in the same cycle the limit is reached, done wins.
- CALC_TIMEOUT_EN undefined: no counter; WAIT exits only on i_calc_done or reset. Code 100 is never produced.

## Test plan
- Multiply op1 2x3, op2 3x4, i_calc_done 10 cycles after start → one o_start_calc pulse; o_core_sel high 11 cycles; o_done with o_err=0; o_res 2x4.
- Add op1 2x3, op2 3x2 → o_done cycle 2, o_err=1, code 011, o_start_calc never asserted.
- Op code 111 with dims 6x6 → code 001 (op outranks range). Transpose 6x1 → code 010.
- Transpose 3x5 → o_res 5x3; i_req held high → second request accepted the cycle after o_done.
- rst pulse during WAIT → o_core_sel and o_busy 0 asynchronously; a later i_calc_done produces no o_done.
- With CALC_TIMEOUT_EN, TIMEOUT_CYCLES=16, no i_calc_done → ERR code 100 after 16 WAIT cycles. Without the macro → o_busy stays high indefinitely.
